gbp_update_ctrl: RTL

Feeds the global branch predictor's update port. It captures each dispatched conditional branch's prediction and metadata index, then waits for the execute stage to resolve the branch, out of order if needed. It retires entries in program order and emits one registered predictor update per retired branch. It sits between the frontend/issue path, which consumes `bht_prediction_o` of the predictor, and the predictor's `bht_update_i`.

---
 rtl/gbp_update_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gbp_update_ctrl.sv
// -----------------------------------------------------------------------------
// gbp_update_ctrl
//
// In-order retirement buffer that feeds the global branch predictor's update
// port. Every dispatched conditional branch gets an entry. The entry captures
// the branch PC, the predicted direction and the predictor metadata index.
// The execute stage then resolves entries by tag, in any order. Entries retire
// strictly in program order, at most one per cycle. Each retire produces one
// registered predictor update.
//
// Optional feature (compile-time macro GBP_UPD_MISPRED_CNT_EN):
//   adds a saturating 32-bit mispredict counter on mispred_cnt_o. Only reset
//   clears it; flush does not.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   flush_i                squash all outstanding entries
//   debug_mode_i           retire without raising update_valid_o
//   pred_valid_i/ready_o   allocation handshake; pred_id_o is the tag issued
//   pred_pc_i, pred_taken_i, pred_index_i   prediction payload
//   resolve_valid_i, resolve_id_i, resolve_taken_i   out-of-order resolution
//   update_valid_o, update_pc_o, update_taken_o, update_index_o, mispredict_o
//                          registered predictor update, one pulse per retire
//   count_o                number of occupied entries
// -----------------------------------------------------------------------------
module gbp_update_ctrl #(
  parameter int VLEN       = 64,
  parameter int INDEX_BITS = 10,
  parameter int DEPTH      = 8,
  parameter int ID_W       = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  logic                  pred_valid_i,
  output logic                  pred_ready_o,
  input  logic [VLEN-1:0]       pred_pc_i,
  input  logic                  pred_taken_i,
  input  logic [INDEX_BITS-1:0] pred_index_i,
  output logic [ID_W-1:0]       pred_id_o,
  input  logic                  resolve_valid_i,
  input  logic [ID_W-1:0]       resolve_id_i,
  input  logic                  resolve_taken_i,
  output logic                  update_valid_o,
  output logic [VLEN-1:0]       update_pc_o,
  output logic                  update_taken_o,
  output logic [INDEX_BITS-1:0] update_index_o,
  output logic                  mispredict_o,
  output logic [ID_W:0]         count_o
`ifdef GBP_UPD_MISPRED_CNT_EN
  ,
  output logic [31:0]           mispred_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_RESOLVED = 2'd2
  } entry_state_e;

  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

  entry_state_e          state_q      [DEPTH];
  logic [VLEN-1:0]       pc_q         [DEPTH];
  logic                  pred_taken_q [DEPTH];
  logic                  act_taken_q  [DEPTH];
  logic [INDEX_BITS-1:0] index_q      [DEPTH];

  logic [ID_W-1:0] head_q;
  logic [ID_W-1:0] tail_q;
  logic [ID_W:0]   count_q;

  logic alloc;
  logic resolve_hit;
  logic retire;

  // Ready looks only at the registered count. A retire in the same cycle
  // does not open a slot until the next cycle.
  assign pred_ready_o = (count_q != FULL_CNT);
  assign pred_id_o    = tail_q;
  assign count_o      = count_q;

  assign alloc = pred_valid_i && pred_ready_o && !flush_i;

  // Only a PENDING entry can resolve. The tail entry is FREE, so a resolve
  // aimed at the slot being allocated this cycle is dropped here as well.
  assign resolve_hit = resolve_valid_i && !flush_i &&
                       (state_q[resolve_id_i] == ST_PENDING);

  // The head can retire only while it is RESOLVED. A resolve on the head
  // therefore retires one edge later.
  assign retire = !flush_i && (state_q[head_q] == ST_RESOLVED);

  // Entry state and pointers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // alloc, resolve and retire always target distinct slots: the tail is
      // FREE, a resolve needs PENDING, and a retire needs RESOLVED.
      if (alloc)       state_q[tail_q]       <= ST_PENDING;
      if (resolve_hit) state_q[resolve_id_i] <= ST_RESOLVED;
      if (retire)      state_q[head_q]       <= ST_FREE;

      if (alloc)  tail_q <= tail_q + ID_W'(1);
      if (retire) head_q <= head_q + ID_W'(1);

      unique case ({alloc, retire})
        2'b10:   count_q <= count_q + (ID_W+1)'(1);
        2'b01:   count_q <= count_q - (ID_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload.
  // NOTE: the payload storage is deliberately not reset. An entry's fields
  // are always written when the entry becomes PENDING or RESOLVED, before
  // anything reads them. Keeping reset off lets the storage map onto plain
  // memory.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      pc_q[tail_q]         <= pred_pc_i;
      pred_taken_q[tail_q] <= pred_taken_i;
      index_q[tail_q]      <= pred_index_i;
    end
    if (resolve_hit) act_taken_q[resolve_id_i] <= resolve_taken_i;
  end

  // Registered predictor update. The data fields hold their last loaded
  // value; only the valid bit is cleared between retires.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      update_valid_o <= 1'b0;
      update_pc_o    <= '0;
      update_taken_o <= 1'b0;
      update_index_o <= '0;
      mispredict_o   <= 1'b0;
    end else if (flush_i) begin
      update_valid_o <= 1'b0;
    end else begin
      // A retire in debug mode still frees the entry, but the predictor does
      // not train on it.
      update_valid_o <= retire && !debug_mode_i;
      if (retire) begin
        update_pc_o    <= pc_q[head_q];
        update_taken_o <= act_taken_q[head_q];
        update_index_o <= index_q[head_q];
        mispredict_o   <= act_taken_q[head_q] ^ pred_taken_q[head_q];
      end
    end
  end

`ifdef GBP_UPD_MISPRED_CNT_EN
  logic [31:0] mispred_cnt_q;

  // Counts the mispredict updates that are visible on the port. It saturates
  // instead of wrapping, and a flush leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mispred_cnt_q <= '0;
    end else if (update_valid_o && mispredict_o && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule
